// File: rtl/vscpu_pkg.sv
// Shared definitions for the VerySimpleCPU boot loader: default geometry and
// the loader state encoding.
package vscpu_pkg;

  localparam int SIZE_DEF  = 14;
  localparam int DEPTH_DEF = 1024;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    RUN    = 3'd4,
    ERR    = 3'd5
  } ld_state_e;

endpackage

// File: rtl/vscpu_ram_mux.sv
// RAM port select: the CPU owns the blram port while running, the loader
// owns it otherwise.
module vscpu_ram_mux #(
  parameter int SIZE = 14
) (
  input  logic            i_sel_cpu,
  input  logic            i_ld_we,
  input  logic [SIZE-1:0] i_ld_addr,
  input  logic [31:0]     i_ld_data,
  input  logic            i_cpu_we,
  input  logic [SIZE-1:0] i_cpu_addr,
  input  logic [31:0]     i_cpu_data,
  output logic            o_ram_we,
  output logic [SIZE-1:0] o_ram_addr,
  output logic [31:0]     o_ram_data
);

  assign o_ram_we   = i_sel_cpu ? i_cpu_we   : i_ld_we;
  assign o_ram_addr = i_sel_cpu ? i_cpu_addr : i_ld_addr;
  assign o_ram_data = i_sel_cpu ? i_cpu_data : i_ld_data;

endmodule

// File: rtl/vscpu_boot_loader.sv
// Boot loader: receives a counted, XOR-checksummed byte stream, writes the
// words to blram from address 0, then releases the CPU onto the RAM port.
module vscpu_boot_loader
  import vscpu_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  input  logic            reload,
  output logic            cpu_rst,
  input  logic            cpu_wrEn,
  input  logic [SIZE-1:0] cpu_addr,
  input  logic [31:0]     cpu_data,
  output logic            ram_we,
  output logic [SIZE-1:0] ram_addr,
  output logic [31:0]     ram_data,
  output logic            load_done,
  output logic            load_err
);

  ld_state_e       r_state, w_state_next;
  logic [15:0]     r_cnt;
  logic [SIZE-1:0] r_word_idx;
  logic [1:0]      r_byte_idx;
  logic [31:0]     r_asm;
  logic [7:0]      r_chk;
  logic            r_we;
  logic [SIZE-1:0] r_addr;
  logic [31:0]     r_data;
  logic            r_cpu_rst;

  logic            w_fire;
  logic            w_clear;
  logic            w_word_done;
  logic            w_last_word;
  logic            w_sel_cpu;
  logic [16:0]     w_n_hdr;
  logic [31:0]     w_word;

  // Header count widened to 17 bits so that N == DEPTH is accepted.
  assign w_n_hdr     = {1'b0, r_cnt[15:8], in_data};
  assign w_word      = {r_asm[23:0], in_data};
  assign w_last_word = (32'(r_word_idx) + 32'd1) == 32'(r_cnt);
  assign w_sel_cpu   = (r_state == RUN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= HDR_HI;
    else      r_state <= w_state_next;
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    load_done    = 1'b0;
    load_err     = 1'b0;
    w_clear      = 1'b0;
    w_word_done  = 1'b0;
    case (r_state)
      HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = HDR_LO;
      end
      HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (w_n_hdr > 17'(DEPTH))  w_state_next = ERR;
          else if (w_n_hdr == 17'd0) w_state_next = CHK;
          else                       w_state_next = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid && r_byte_idx == 2'd3) begin
          w_word_done = 1'b1;
          if (w_last_word) w_state_next = CHK;
        end
      end
      CHK: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = (in_data == r_chk) ? RUN : ERR;
      end
      RUN: begin
        load_done = 1'b1;
        if (reload) begin
          w_clear      = 1'b1;
          w_state_next = HDR_HI;
        end
      end
      ERR: begin
        load_err = 1'b1;
        if (reload) begin
          w_clear      = 1'b1;
          w_state_next = HDR_HI;
        end
      end
      default: w_state_next = HDR_HI;
    endcase
    w_fire = in_valid && in_ready;
  end

  // The write pulse lands in the cycle after the 4th byte; for the last word
  // that cycle is already CHK, so the write finishes before RUN/ERR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_asm      <= '0;
      r_chk      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cpu_rst  <= 1'b1;
    end else begin
      r_we      <= 1'b0;
      r_cpu_rst <= !((r_state == RUN) && !reload);
      if (w_clear) begin
        r_cnt      <= '0;
        r_word_idx <= '0;
        r_byte_idx <= '0;
        r_asm      <= '0;
        r_chk      <= '0;
        r_addr     <= '0;
        r_data     <= '0;
      end else if (w_fire) begin
        case (r_state)
          HDR_HI: r_cnt[15:8] <= in_data;
          HDR_LO: r_cnt[7:0]  <= in_data;
          DATA: begin
            r_asm      <= w_word;
            r_chk      <= r_chk ^ in_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_word_done) begin
              r_we       <= 1'b1;
              r_addr     <= r_word_idx;
              r_data     <= w_word;
              r_word_idx <= r_word_idx + SIZE'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cpu_rst = r_cpu_rst;

  vscpu_ram_mux #(.SIZE(SIZE)) u_ram_mux (
    .i_sel_cpu  (w_sel_cpu),
    .i_ld_we    (r_we),
    .i_ld_addr  (r_addr),
    .i_ld_data  (r_data),
    .i_cpu_we   (cpu_wrEn),
    .i_cpu_addr (cpu_addr),
    .i_cpu_data (cpu_data),
    .o_ram_we   (ram_we),
    .o_ram_addr (ram_addr),
    .o_ram_data (ram_data)
  );

endmodule

// File: tb/tb_vscpu_boot_loader.sv
// Self-checking bench for vscpu_boot_loader: a cycle-accurate vector table for
// the basic load/run/reload flow, plus directed frame-level sequences.
module tb_vscpu_boot_loader;

  localparam int SIZE  = 14;
  localparam int DEPTH = 1024;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_ready;
  logic            reload;
  logic            cpu_rst;
  logic            cpu_wrEn;
  logic [SIZE-1:0] cpu_addr;
  logic [31:0]     cpu_data;
  logic            ram_we;
  logic [SIZE-1:0] ram_addr;
  logic [31:0]     ram_data;
  logic            load_done;
  logic            load_err;

  int n_checks = 0;
  int n_fails  = 0;

  vscpu_boot_loader #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .cpu_rst   (cpu_rst),
    .cpu_wrEn  (cpu_wrEn),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // Write log: every RAM write pulse seen on the port, sampled mid-cycle.
  logic [31:0] wr_mem [0:16383];
  int          wr_cnt  = 0;
  int          wr_last = -1;
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_mem[ram_addr] = ram_data;
      wr_cnt++;
      wr_last = int'(ram_addr);
    end
  end

  logic [31:0] fw [0:1023];

  typedef struct {
    logic            v;
    logic [7:0]      d;
    logic            rl;
    logic            cwe;
    logic [SIZE-1:0] caddr;
    logic [31:0]     cdata;
    logic            e_rdy;
    logic            e_we;
    logic [SIZE-1:0] e_addr;
    logic [31:0]     e_data;
    logic            e_done;
    logic            e_err;
    logic            e_crst;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(logic v, logic [7:0] d, logic rl, logic cwe,
                              logic [SIZE-1:0] ca, logic [31:0] cd,
                              logic rdy, logic we, logic [SIZE-1:0] a,
                              logic [31:0] dat, logic dn, logic er, logic cr);
    vec_t r;
    r = '{v, d, rl, cwe, ca, cd, rdy, we, a, dat, dn, er, cr};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_cnt  = 0;
    wr_last = -1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    check("in_ready_during_load", in_ready, 1'b1);
  endtask

  function automatic int pick_gap(input int max_gap);
    return (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
  endfunction

  // Builds the frame from fw[], with the checksum computed here and
  // optionally corrupted by XOR with flip.
  task automatic send_frame(input int n, input logic [7:0] flip, input int max_gap);
    logic [7:0] c;
    logic [7:0] b;
    logic [31:0] w;
    c = 8'h00;
    send_byte(8'(n >> 8), pick_gap(max_gap));
    send_byte(8'(n), pick_gap(max_gap));
    for (int i = 0; i < n; i++) begin
      w = fw[i];
      for (int j = 3; j >= 0; j--) begin
        b = w[8*j +: 8];
        c = c ^ b;
        send_byte(b, pick_gap(max_gap));
      end
    end
    send_byte(c ^ flip, pick_gap(max_gap));
    idle();
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    @(negedge clk);
    while (!(load_done || load_err) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("frame_end_within_budget", 32'(load_done || load_err), 32'd1);
  endtask

  task automatic pulse_reload();
    @(posedge clk); #1;
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    @(negedge clk);
    check("reload.cpu_rst", cpu_rst, 1'b1);
    check("reload.in_ready", in_ready, 1'b1);
    check("reload.load_done", load_done, 1'b0);
    check("reload.load_err", load_err, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"}, in_ready, 1'b1);
    check({tag, ".cpu_rst"}, cpu_rst, 1'b1);
    check({tag, ".ram_we"}, ram_we, 1'b0);
    check({tag, ".ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, ".ram_data"}, ram_data, 32'd0);
    check({tag, ".load_done"}, load_done, 1'b0);
    check({tag, ".load_err"}, load_err, 1'b0);
  endtask

  task automatic set_frame1();
    fw[0] = 32'h20114045;
    fw[1] = 32'h10114001;
    fw[2] = 32'hb0118064;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;

    // Frame 1 cycle by cycle: checksum of the 12 data bytes is 0x31.
    vecs[0]  = mk(1, 8'h00, 0, 0, 0, 0,   1, 0, 0, 32'h0,        0, 0, 1);
    vecs[1]  = mk(1, 8'h03, 0, 0, 0, 0,   1, 0, 0, 32'h0,        0, 0, 1);
    vecs[2]  = mk(1, 8'h20, 0, 0, 0, 0,   1, 0, 0, 32'h0,        0, 0, 1);
    vecs[3]  = mk(1, 8'h11, 0, 0, 0, 0,   1, 0, 0, 32'h0,        0, 0, 1);
    vecs[4]  = mk(1, 8'h40, 0, 0, 0, 0,   1, 0, 0, 32'h0,        0, 0, 1);
    vecs[5]  = mk(1, 8'h45, 0, 0, 0, 0,   1, 0, 0, 32'h0,        0, 0, 1);
    vecs[6]  = mk(1, 8'h10, 0, 0, 0, 0,   1, 1, 0, 32'h20114045, 0, 0, 1);
    vecs[7]  = mk(1, 8'h11, 0, 0, 0, 0,   1, 0, 0, 32'h20114045, 0, 0, 1);
    vecs[8]  = mk(1, 8'h40, 0, 0, 0, 0,   1, 0, 0, 32'h20114045, 0, 0, 1);
    vecs[9]  = mk(1, 8'h01, 0, 0, 0, 0,   1, 0, 0, 32'h20114045, 0, 0, 1);
    vecs[10] = mk(1, 8'hb0, 0, 0, 0, 0,   1, 1, 1, 32'h10114001, 0, 0, 1);
    vecs[11] = mk(1, 8'h11, 0, 0, 0, 0,   1, 0, 1, 32'h10114001, 0, 0, 1);
    vecs[12] = mk(1, 8'h80, 0, 0, 0, 0,   1, 0, 1, 32'h10114001, 0, 0, 1);
    vecs[13] = mk(1, 8'h64, 0, 0, 0, 0,   1, 0, 1, 32'h10114001, 0, 0, 1);
    vecs[14] = mk(1, 8'h31, 0, 0, 0, 0,   1, 1, 2, 32'hb0118064, 0, 0, 1);
    vecs[15] = mk(0, 8'h00, 0, 0, 0, 0,   0, 0, 0, 32'h0,        1, 0, 1);
    vecs[16] = mk(0, 8'h00, 0, 1, 101, 6, 0, 1, 101, 32'h6,      1, 0, 0);
    vecs[17] = mk(0, 8'h00, 1, 0, 0, 0,   0, 0, 0, 32'h0,        1, 0, 0);
    vecs[18] = mk(0, 8'h00, 0, 1, 55, 77, 1, 0, 0, 32'h0,        0, 0, 1);

    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    cpu_wrEn = 1'b0;
    cpu_addr = '0;
    cpu_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      reload   = vecs[i].rl;
      cpu_wrEn = vecs[i].cwe;
      cpu_addr = vecs[i].caddr;
      cpu_data = vecs[i].cdata;
      @(negedge clk);
      check($sformatf("vec%0d.in_ready", i), in_ready, vecs[i].e_rdy);
      check($sformatf("vec%0d.ram_we", i), ram_we, vecs[i].e_we);
      check($sformatf("vec%0d.ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d.ram_data", i), ram_data, vecs[i].e_data);
      check($sformatf("vec%0d.load_done", i), load_done, vecs[i].e_done);
      check($sformatf("vec%0d.load_err", i), load_err, vecs[i].e_err);
      check($sformatf("vec%0d.cpu_rst", i), cpu_rst, vecs[i].e_crst);
    end
    @(posedge clk); #1;
    cpu_wrEn = 1'b0;
    cpu_addr = '0;
    cpu_data = '0;

    // Second frame after reload loads cleanly; cpu_rst drops one cycle into RUN.
    set_frame1();
    clear_log();
    send_frame(3, 8'h00, 0);
    wait_end();
    check("t1.load_done", load_done, 1'b1);
    check("t1.load_err", load_err, 1'b0);
    check("t1.cpu_rst_first_run_cycle", cpu_rst, 1'b1);
    @(negedge clk);
    check("t1.cpu_rst_released", cpu_rst, 1'b0);
    check("t1.write_count", 32'(wr_cnt), 32'd3);
    check("t1.mem0", wr_mem[0], 32'h20114045);
    check("t1.mem1", wr_mem[1], 32'h10114001);
    check("t1.mem2", wr_mem[2], 32'hb0118064);

    // Corrupted checksum: all writes still happen, CPU stays held, port locked.
    pulse_reload();
    clear_log();
    send_frame(3, 8'hff, 0);
    wait_end();
    check("t2.load_err", load_err, 1'b1);
    check("t2.load_done", load_done, 1'b0);
    check("t2.write_count", 32'(wr_cnt), 32'd3);
    check("t2.mem2", wr_mem[2], 32'hb0118064);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      cpu_wrEn = k[0];
      cpu_addr = SIZE'(k + 200);
      cpu_data = 32'(k) ^ 32'hdead0000;
      @(negedge clk);
      check($sformatf("t2.err_ram_we%0d", k), ram_we, 1'b0);
      check($sformatf("t2.err_cpu_rst%0d", k), cpu_rst, 1'b1);
      check($sformatf("t2.err_in_ready%0d", k), in_ready, 1'b0);
    end
    @(posedge clk); #1;
    cpu_wrEn = 1'b0;
    cpu_addr = '0;
    cpu_data = '0;

    // Empty image, with a reload pulse mid-header that must be ignored.
    pulse_reload();
    clear_log();
    send_byte(8'h00, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reload   = 1'b1;
    @(posedge clk); #1;
    reload   = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    idle();
    wait_end();
    check("t3.n0_load_done", load_done, 1'b1);
    check("t3.n0_write_count", 32'(wr_cnt), 32'd0);

    // Oversized count is rejected as soon as CNT_LO is taken.
    pulse_reload();
    clear_log();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    idle();
    @(negedge clk);
    check("t3.n1025_load_err", load_err, 1'b1);
    check("t3.n1025_in_ready", in_ready, 1'b0);
    check("t3.n1025_cpu_rst", cpu_rst, 1'b1);
    check("t3.n1025_write_count", 32'(wr_cnt), 32'd0);

    // Full-depth image with random idle gaps between bytes.
    pulse_reload();
    for (int i = 0; i < DEPTH; i++)
      fw[i] = {8'(i), 8'(i >> 8), ~8'(i), 8'hc3};
    clear_log();
    send_frame(DEPTH, 8'h00, 5);
    wait_end();
    check("t4.load_done", load_done, 1'b1);
    check("t4.load_err", load_err, 1'b0);
    check("t4.write_count", 32'(wr_cnt), 32'(DEPTH));
    check("t4.last_addr", 32'(wr_last), 32'(DEPTH - 1));
    mism = 0;
    for (int i = 0; i < DEPTH; i++)
      if (wr_mem[i] !== fw[i]) mism++;
    check("t4.mem_mismatches", 32'(mism), 32'd0);

    // Reset in the middle of a frame, then a clean reload.
    pulse_reload();
    set_frame1();
    clear_log();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 2; i++)
      for (int j = 3; j >= 0; j--)
        send_byte(fw[i][8*j +: 8], 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6.async_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    clear_log();
    send_frame(3, 8'h00, 0);
    wait_end();
    check("t6.load_done", load_done, 1'b1);
    check("t6.write_count", 32'(wr_cnt), 32'd3);
    check("t6.mem0", wr_mem[0], 32'h20114045);
    check("t6.mem1", wr_mem[1], 32'h10114001);
    check("t6.mem2", wr_mem[2], 32'hb0118064);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
